// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction-fetch stage. Issues at most one outstanding
//                instruction-memory request, steers the response into the
//                IF/ID register or a one-entry skid buffer when decode is
//                stalled, and drops responses that belong to a flushed fetch.
//
//  Ports
//    clk, rst          rising-edge clock, synchronous active-high reset
//    pc_in             current PC from the PC register
//    pc_advance        pulse: request accepted, PC register may step
//    imem_req/addr     fetch request and address (address = pc_in)
//    imem_ready        memory accepts the request this cycle
//    imem_rvalid/rdata response handshake and instruction word
//    id_stall          decode cannot take a new instruction
//    flush             redirect; discard everything in flight
//    ifid_valid/instr/pc/pc4  IF/ID register contents
//    misalign_err      pulse: pc_in is not word-aligned
//
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        flush,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        misalign_err
);

    // Fetch state: REQ = free to issue, WAIT = one request outstanding,
    // DROP = outstanding request belongs to a flushed path.
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [31:0] c_PC_STEP = 32'd4;

    logic [1:0]  r_state;
    logic [31:0] r_pend_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    logic        w_misaligned;
    logic        w_in_req;
    logic        w_accept;
    logic        w_resp;

    assign w_misaligned = (pc_in[1:0] != 2'b00);
    assign w_in_req     = (r_state == S_REQ) && !rst && !flush;

    // A full skid buffer blocks new requests so that at most two fetched
    // instructions (IF/ID + skid) are ever held.
    assign imem_req     = w_in_req && !r_skid_valid && !w_misaligned;
    assign w_accept     = imem_req && imem_ready;
    assign pc_advance   = w_accept;
    assign misalign_err = w_in_req && w_misaligned;
    assign imem_addr    = pc_in;

    // Only a response to a live request counts; rvalid in REQ or DROP is
    // either stale (after reset) or belongs to a flushed fetch.
    assign w_resp = (r_state == S_WAIT) && imem_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pend_pc    <= 32'd0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= 32'd0;
            r_skid_pc    <= 32'd0;
            ifid_valid   <= 1'b0;
            ifid_instr   <= 32'd0;
            ifid_pc      <= 32'd0;
            ifid_pc4     <= c_PC_STEP;
        end else if (flush) begin
            // Flush wins over stall and any same-cycle response.
            ifid_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
            if (r_state == S_WAIT) begin
                r_state <= S_DROP;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        r_pend_pc <= pc_in;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase

            if (ifid_valid && id_stall) begin
                // Decode is holding IF/ID; park a new response in the skid.
                if (w_resp) begin
                    r_skid_valid <= 1'b1;
                    r_skid_instr <= imem_rdata;
                    r_skid_pc    <= r_pend_pc;
                end
            end else if (r_skid_valid) begin
                // The skid entry is older than anything still in flight,
                // and no request can be outstanding while it is full.
                r_skid_valid <= 1'b0;
                ifid_valid   <= 1'b1;
                ifid_instr   <= r_skid_instr;
                ifid_pc      <= r_skid_pc;
                ifid_pc4     <= r_skid_pc + c_PC_STEP;
            end else if (w_resp) begin
                ifid_valid <= 1'b1;
                ifid_instr <= imem_rdata;
                ifid_pc    <= r_pend_pc;
                ifid_pc4   <= r_pend_pc + c_PC_STEP;
            end else begin
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
REQ-002 The block SHALL have the following pc-side ports:
  pc_in  in  32  current PC, from the PC register
  pc_advance  out  1  one-cycle pulse; the PC register may load the next PC
REQ-003 The block SHALL have the following instruction-memory ports:
  imem_req  out  1  fetch request
  imem_addr  out  32  fetch address
  imem_ready  in  1  memory accepts the request this cycle
  imem_rvalid  in  1  response data valid
  imem_rdata  in  32  instruction word
REQ-004 The block SHALL have the following decode-side ports:
  id_stall  in  1  decode cannot accept a new instruction
  flush  in  1  redirect; discard everything fetched
  ifid_valid  out  1  IF/ID register holds an instruction
  ifid_instr  out  32  fetched instruction
  ifid_pc  out  32  PC of ifid_instr
  ifid_pc4  out  32  ifid_pc + 4
  misalign_err  out  1  pulse: pc_in not word-aligned

Function
REQ-005 The block SHALL implement states REQ, WAIT and DROP, and SHALL allow at most one outstanding request.
REQ-006 imem_req SHALL be 1 only when all of the following hold: state is REQ, rst=0, flush=0, skid buffer empty, and pc_in[1:0]=00.
REQ-007 imem_addr SHALL equal pc_in combinationally at all times.
REQ-008 A request SHALL be accepted in any cycle with imem_req=1 and imem_ready=1.
REQ-009 On request acceptance, pc_advance SHALL be 1 in that same cycle, the block SHALL latch pc_in as the pending PC, and the state SHALL go REQ->WAIT.
REQ-010 When imem_req=1 and imem_ready=0, the block SHALL stay in REQ and hold imem_req; pc_advance SHALL be 0.
REQ-011 In WAIT with imem_rvalid=1, the block SHALL route the response as follows and then go WAIT->REQ:
  - if ifid_valid=0 or id_stall=0: load IF/ID with instr=imem_rdata, pc=pending PC, pc4=pending PC+4 (mod 2^32), ifid_valid=1.
  - otherwise: capture {imem_rdata, pending PC} into the 1-entry skid buffer.
REQ-012 Memory response latency SHALL be 1 or more cycles.
REQ-013 An imem_rvalid received in REQ state SHALL be ignored.
REQ-014 When the skid buffer is full and id_stall=0, the skid entry SHALL move into IF/ID on the next edge and the buffer SHALL empty; no new request SHALL be issued while the buffer is full.
REQ-015 When id_stall=0, ifid_valid=1 and no new data arrives, ifid_valid SHALL clear on the next edge.
REQ-016 When id_stall=1, the IF/ID contents SHALL hold unchanged.
REQ-017 On flush=1, the next edge SHALL:
  - clear ifid_valid and the skid buffer;
  - move WAIT->DROP;
  - leave REQ unchanged.
  flush SHALL override id_stall and any same-cycle imem_rvalid.
REQ-018 In DROP, imem_req SHALL be 0; on imem_rvalid=1 the data SHALL be discarded and the state SHALL go DROP->REQ. A flush in DROP SHALL keep the state in DROP.
REQ-019 In REQ with pc_in[1:0]!=00 and flush=0, misalign_err SHALL be 1 that cycle, no request SHALL be issued and pc_advance SHALL be 0; the state SHALL remain REQ until pc_in changes or a flush occurs.
REQ-020 A PC of 0xFFFFFFFC SHALL yield ifid_pc4=0x00000000 (wrap-around).
REQ-021 The block SHALL never drop, duplicate or reorder an accepted, non-flushed instruction.

Reset
REQ-022 With rst=1 at a rising edge, the next state SHALL be:
  - state=REQ
  - ifid_valid=0, ifid_instr=0x00000000 (NOP), ifid_pc=0, ifid_pc4=4
  - skid buffer empty, pending PC=0
REQ-023 While rst=1, imem_req, pc_advance and misalign_err SHALL be 0.
REQ-024 A reset asserted in WAIT or DROP SHALL abandon the outstanding request; a late imem_rvalid arriving in REQ after reset SHALL be ignored.
REQ-025 The first request SHALL be issued in the first cycle with rst=0.

Verification
REQ-026 Basic fetch:
  - stimulus: pc_in=0x00000000, imem_ready=1, 1-cycle latency, rdata=0x20080005, id_stall=0
  - response: pc_advance pulses; 2 cycles later ifid_valid=1, ifid_instr=0x20080005, ifid_pc=0, ifid_pc4=4.
REQ-027 Stall plus skid:
  - stimulus: id_stall held at 1 across two responses, 0xAAAA0000 then 0xBBBB0000
  - response: IF/ID holds 0xAAAA0000, skid holds 0xBBBB0000, imem_req=0; after id_stall drops, 0xBBBB0000 appears next with its correct PC.
REQ-028 Flush while outstanding:
  - stimulus: flush=1 in WAIT; imem_rvalid arrives 3 cycles later with 0xDEADBEEF
  - response: 0xDEADBEEF never appears on ifid_instr; ifid_valid=0; the next request uses the new pc_in.
REQ-029 Memory backpressure:
  - stimulus: imem_ready=0 for 4 cycles
  - response: imem_req held at 1, imem_addr stable, pc_advance=0 until the cycle imem_ready=1.
REQ-030 Misalign and wrap:
  - stimulus: pc_in=0x00000006
  - response: misalign_err=1 and no imem_req.
  - stimulus: pc_in=0xFFFFFFFC
  - response: ifid_pc4=0x00000000.
REQ-031 Reset mid-fetch:
  - stimulus: rst=1 in WAIT, then a late imem_rvalid
  - response: ifid_valid=0, ifid_instr=0, and the late data is ignored.
